// File: rtl/wave_period_meter_if.sv
// Sample stream into the period meter and the measurement results coming back out.
// master = sample source / result consumer, slave = the meter.
interface wave_period_meter_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic [CNT_W-1:0]  period;
  logic [DATA_W-1:0] amp_max;
  logic [DATA_W-1:0] amp_min;
  logic              meas_valid;
  logic              no_signal;

  modport master (
    output sample_valid, sample_in,
    input  period, amp_max, amp_min, meas_valid, no_signal
  );

  modport slave (
    input  sample_valid, sample_in,
    output period, amp_max, amp_min, meas_valid, no_signal
  );
endinterface

// File: rtl/wave_period_meter.sv
// Measures waveform period in accepted samples and per-period min/max amplitude,
// using a hysteresis comparator around THRESH to find rising crossings.
//
// state    | meaning
// SEEK_LOW | waiting for a sample below the band before arming
// ARM      | seen low, waiting for the first rising crossing
// HIGH     | counting, last decision was high
// LOW      | counting, last decision was low; next high sample is a crossing
module wave_period_meter #(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 16,
  parameter int THRESH     = 128,
  parameter int HYST       = 16,
  parameter int MAX_PERIOD = 65535
) (
  input logic clk,
  input logic reset,
  wave_period_meter_if.slave bus
);
  localparam logic [DATA_W-1:0] LO_LVL  = DATA_W'(THRESH - HYST);
  localparam logic [DATA_W-1:0] HI_LVL  = DATA_W'(THRESH + HYST);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_PERIOD);

  typedef enum logic [1:0] {SEEK_LOW, ARM, HIGH, LOW} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] run_max, run_max_n, run_min, run_min_n;
  logic [CNT_W-1:0]  period_q, period_n;
  logic [DATA_W-1:0] amp_max_q, amp_max_n, amp_min_q, amp_min_n;
  logic              meas_valid_q, meas_valid_n;
  logic              no_signal_q, no_signal_n;

  logic              is_low, is_high;
  logic [DATA_W-1:0] s;

  assign s       = bus.sample_in;
  assign is_low  = (s < LO_LVL);
  assign is_high = (s >= HI_LVL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SEEK_LOW;
      cnt          <= '0;
      run_max      <= '0;
      run_min      <= '1;
      period_q     <= '0;
      amp_max_q    <= '0;
      amp_min_q    <= '0;
      meas_valid_q <= 1'b0;
      no_signal_q  <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      run_max      <= run_max_n;
      run_min      <= run_min_n;
      period_q     <= period_n;
      amp_max_q    <= amp_max_n;
      amp_min_q    <= amp_min_n;
      meas_valid_q <= meas_valid_n;
      no_signal_q  <= no_signal_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    run_max_n    = run_max;
    run_min_n    = run_min;
    period_n     = period_q;
    amp_max_n    = amp_max_q;
    amp_min_n    = amp_min_q;
    meas_valid_n = 1'b0;
    no_signal_n  = no_signal_q;

    if (bus.sample_valid) begin
      case (state)
        SEEK_LOW: if (is_low) state_n = ARM;
        ARM: begin
          if (is_high) begin
            state_n   = HIGH;
            cnt_n     = CNT_W'(1);
            run_max_n = s;
            run_min_n = s;
          end
        end
        HIGH, LOW: begin
          if (state == LOW && is_high) begin
            // Crossing sample starts the next period; it is excluded from the stats just published.
            period_n     = cnt;
            amp_max_n    = run_max;
            amp_min_n    = run_min;
            meas_valid_n = 1'b1;
            no_signal_n  = 1'b0;
            cnt_n        = CNT_W'(1);
            run_max_n    = s;
            run_min_n    = s;
            state_n      = HIGH;
          end else if (cnt == CNT_MAX) begin
            no_signal_n = 1'b1;
            cnt_n       = '0;
            state_n     = SEEK_LOW;
          end else begin
            cnt_n = cnt + CNT_W'(1);
            if (s > run_max) run_max_n = s;
            if (s < run_min) run_min_n = s;
            if (state == HIGH && is_low) state_n = LOW;
          end
        end
        default: state_n = SEEK_LOW;
      endcase
    end
  end

  assign bus.period     = period_q;
  assign bus.amp_max    = amp_max_q;
  assign bus.amp_min    = amp_min_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.no_signal  = no_signal_q;
endmodule

// File: tb/tb_wave_period_meter.sv
// Directed bench for wave_period_meter: square, sparse-valid square, triangle,
// in-band noise, timeout, crossing at the period limit and mid-period reset.
module tb_wave_period_meter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc;

  wave_period_meter_if #(.DATA_W(8), .CNT_W(16)) bus ();

  wave_period_meter #(
    .DATA_W(8), .CNT_W(16), .THRESH(128), .HYST(16), .MAX_PERIOD(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample, let the next rising edge take it, then settle past the edge.
  task automatic send(input logic v, input logic [7:0] smp);
    bus.sample_valid = v;
    bus.sample_in    = smp;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_period"}, 32'(bus.period), 0);
    chk({tag, "_amp_max"}, 32'(bus.amp_max), 0);
    chk({tag, "_amp_min"}, 32'(bus.amp_min), 0);
    chk({tag, "_meas_valid"}, 32'(bus.meas_valid), 0);
    chk({tag, "_no_signal"}, 32'(bus.no_signal), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // Square 8 low / 8 high, valid every cycle
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) begin
        s = (i < 8) ? 8'd0 : 8'd255;
        send(1'b1, s);
        chk("sq_meas", 32'(bus.meas_valid), (p >= 1 && i == 8) ? 1 : 0);
        if (p == 0) chk("sq_nosig_before", 32'(bus.no_signal), 1);
        if (p >= 1 && i == 8) begin
          chk("sq_period", 32'(bus.period), 16);
          chk("sq_max", 32'(bus.amp_max), 255);
          chk("sq_min", 32'(bus.amp_min), 0);
          chk("sq_nosig", 32'(bus.no_signal), 0);
        end
      end
    end

    // Same square, sample accepted every third cycle
    last_cyc = -1;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) begin
        s = (i < 8) ? 8'd0 : 8'd255;
        send(1'b1, s);
        if (i == 8) begin
          chk("sp_meas", 32'(bus.meas_valid), 1);
          chk("sp_period", 32'(bus.period), 16);
          if (last_cyc >= 0) chk("sp_spacing", 32'(cyc - last_cyc), 48);
          last_cyc = cyc;
        end
        send(1'b0, 8'd255);
        if (i == 8) begin
          chk("sp_pulse_len", 32'(bus.meas_valid), 0);
          chk("sp_hold_period", 32'(bus.period), 16);
        end
        send(1'b0, 8'd0);
      end
    end

    // Triangle 0..255..0 step 17: 30-sample period, crossing at 153
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 30; k++) begin
        s = (k <= 15) ? 8'(17 * k) : 8'(17 * (30 - k));
        send(1'b1, s);
        chk("tri_meas", 32'(bus.meas_valid), (k == 9) ? 1 : 0);
        if (k == 9) begin
          chk("tri_period", 32'(bus.period), (p == 0) ? 17 : 30);
          chk("tri_max", 32'(bus.amp_max), 255);
          chk("tri_min", 32'(bus.amp_min), 0);
        end
      end
    end

    // In-band noise while LOW: no state change, no measurement
    for (int j = 0; j < 20; j++) begin
      send(1'b1, (j % 2) ? 8'd136 : 8'd120);
      chk("noise_meas", 32'(bus.meas_valid), 0);
    end
    // 21 triangle samples since last crossing + 20 noise samples
    send(1'b1, 8'd200);
    chk("noise_xing_meas", 32'(bus.meas_valid), 1);
    chk("noise_xing_period", 32'(bus.period), 41);
    chk("noise_xing_max", 32'(bus.amp_max), 255);
    chk("noise_xing_min", 32'(bus.amp_min), 17);

    // Constant 200: cnt reaches 100, next sample times out
    for (int j = 0; j < 99; j++) send(1'b1, 8'd200);
    chk("to_before_nosig", 32'(bus.no_signal), 0);
    chk("to_before_meas", 32'(bus.meas_valid), 0);
    send(1'b1, 8'd200);
    chk("to_nosig", 32'(bus.no_signal), 1);
    chk("to_period_hold", 32'(bus.period), 41);
    chk("to_max_hold", 32'(bus.amp_max), 255);
    chk("to_min_hold", 32'(bus.amp_min), 17);

    // Crossing exactly at cnt == MAX_PERIOD is a normal measurement
    send(1'b1, 8'd0);
    send(1'b1, 8'd255);
    chk("lim_first_xing_meas", 32'(bus.meas_valid), 0);
    for (int j = 0; j < 49; j++) send(1'b1, 8'd255);
    for (int j = 0; j < 50; j++) send(1'b1, 8'd0);
    chk("lim_nosig_before", 32'(bus.no_signal), 1);
    send(1'b1, 8'd255);
    chk("lim_meas", 32'(bus.meas_valid), 1);
    chk("lim_period", 32'(bus.period), 100);
    chk("lim_nosig", 32'(bus.no_signal), 0);

    // Async reset mid-LOW
    for (int j = 0; j < 8; j++) send(1'b1, 8'd0);
    reset = 1'b1;
    #2;
    chk_reset_vals("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(1'b1, 8'd0);
    for (int j = 0; j < 8; j++) begin
      send(1'b1, 8'd255);
      chk("rst_first_xing_meas", 32'(bus.meas_valid), 0);
    end
    for (int j = 0; j < 8; j++) send(1'b1, 8'd0);
    chk("rst_nosig_before", 32'(bus.no_signal), 1);
    send(1'b1, 8'd255);
    chk("rst_meas", 32'(bus.meas_valid), 1);
    chk("rst_period", 32'(bus.period), 16);
    chk("rst_max", 32'(bus.amp_max), 255);
    chk("rst_min", 32'(bus.amp_min), 0);
    chk("rst_nosig", 32'(bus.no_signal), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
